// File: rtl/alu_rvs.sv
`default_nettype none
// ============================================================================
// Module  : alu_rvs
// Brief   : ALU reservation station with CDB wakeup and dispatch bypass,
//           lowest-index issue selection.
// Revision: 1.0
// ============================================================================
module alu_rvs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             disp_req_i,
  output logic             disp_rdy_o,
  input  logic [3:0]       disp_opc_i,
  input  logic [TAG_W-1:0] disp_tag_i,
  input  logic             disp_src1_vld_i,
  input  logic             disp_src2_vld_i,
  input  logic [TAG_W-1:0] disp_src1_tag_i,
  input  logic [TAG_W-1:0] disp_src2_tag_i,
  input  logic [31:0]      disp_src1_data_i,
  input  logic [31:0]      disp_src2_data_i,
  input  logic             cdb_vld_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_data_i,
  output logic             iss_req_o,
  input  logic             iss_rdy_i,
  output logic [3:0]       iss_opc_o,
  output logic [TAG_W-1:0] iss_tag_o,
  output logic [31:0]      iss_src1_o,
  output logic [31:0]      iss_src2_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] s1v_q, s1v_d;
  logic [DEPTH-1:0] s2v_q, s2v_d;
  logic [3:0]       opc_q [DEPTH];
  logic [3:0]       opc_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [TAG_W-1:0] s1t_q [DEPTH];
  logic [TAG_W-1:0] s1t_d [DEPTH];
  logic [TAG_W-1:0] s2t_q [DEPTH];
  logic [TAG_W-1:0] s2t_d [DEPTH];
  logic [31:0]      s1d_q [DEPTH];
  logic [31:0]      s1d_d [DEPTH];
  logic [31:0]      s2d_q [DEPTH];
  logic [31:0]      s2d_d [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] iss_oh;
  logic             alloc_found;
  logic             iss_found;
  logic             disp_fire;
  logic             iss_fire;
  logic             byp1;
  logic             byp2;

  // Readiness uses registered operand state only, so a wakeup is visible next cycle.
  assign ready = busy_q & s1v_q & s2v_q;

  always_comb begin
    alloc_oh    = '0;
    iss_oh      = '0;
    alloc_found = 1'b0;
    iss_found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
      if (ready[i] && !iss_found) begin
        iss_oh[i] = 1'b1;
        iss_found = 1'b1;
      end
    end
  end

  always_comb begin
    iss_opc_o  = '0;
    iss_tag_o  = '0;
    iss_src1_o = '0;
    iss_src2_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_oh[i]) begin
        iss_opc_o  = opc_q[i];
        iss_tag_o  = tag_q[i];
        iss_src1_o = s1d_q[i];
        iss_src2_o = s2d_q[i];
      end
    end
  end

  assign iss_req_o  = |ready;
  assign disp_rdy_o = ~(&busy_q) & ~flush_i;
  assign disp_fire  = disp_req_i & disp_rdy_o;
  assign iss_fire   = iss_req_o & iss_rdy_i;
  assign byp1       = ~disp_src1_vld_i & cdb_vld_i & (cdb_tag_i == disp_src1_tag_i);
  assign byp2       = ~disp_src2_vld_i & cdb_vld_i & (cdb_tag_i == disp_src2_tag_i);

  always_comb begin
    busy_d = busy_q;
    s1v_d  = s1v_q;
    s2v_d  = s2v_q;
    opc_d  = opc_q;
    tag_d  = tag_q;
    s1t_d  = s1t_q;
    s2t_d  = s2t_q;
    s1d_d  = s1d_q;
    s2d_d  = s2d_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        if (iss_fire && iss_oh[i]) begin
          busy_d[i] = 1'b0;
        end else begin
          if (!s1v_q[i] && cdb_vld_i && (cdb_tag_i == s1t_q[i])) begin
            s1v_d[i] = 1'b1;
            s1d_d[i] = cdb_data_i;
          end
          if (!s2v_q[i] && cdb_vld_i && (cdb_tag_i == s2t_q[i])) begin
            s2v_d[i] = 1'b1;
            s2d_d[i] = cdb_data_i;
          end
        end
      end else if (disp_fire && alloc_oh[i]) begin
        busy_d[i] = 1'b1;
        opc_d[i]  = disp_opc_i;
        tag_d[i]  = disp_tag_i;
        s1t_d[i]  = disp_src1_tag_i;
        s2t_d[i]  = disp_src2_tag_i;
        s1v_d[i]  = disp_src1_vld_i | byp1;
        s2v_d[i]  = disp_src2_vld_i | byp2;
        s1d_d[i]  = byp1 ? cdb_data_i : disp_src1_data_i;
        s2d_d[i]  = byp2 ? cdb_data_i : disp_src2_data_i;
      end
    end
    if (flush_i) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      s1v_q  <= '0;
      s2v_q  <= '0;
    end else begin
      busy_q <= busy_d;
      s1v_q  <= s1v_d;
      s2v_q  <= s2v_d;
      opc_q  <= opc_d;
      tag_q  <= tag_d;
      s1t_q  <= s1t_d;
      s2t_q  <= s2t_d;
      s1d_q  <= s1d_d;
      s2d_q  <= s2d_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rvs.sv
`default_nettype none
// Self-checking bench for alu_rvs: a scoreboard queue holds expected issues in
// the order they must leave the station; a negedge monitor pops on handshake.
module tb_alu_rvs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [3:0]       opc;
    logic [TAG_W-1:0] tag;
    logic [31:0]      s1;
    logic [31:0]      s2;
  } iss_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             disp_req_i;
  logic             disp_rdy_o;
  logic [3:0]       disp_opc_i;
  logic [TAG_W-1:0] disp_tag_i;
  logic             disp_src1_vld_i, disp_src2_vld_i;
  logic [TAG_W-1:0] disp_src1_tag_i, disp_src2_tag_i;
  logic [31:0]      disp_src1_data_i, disp_src2_data_i;
  logic             cdb_vld_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [31:0]      cdb_data_i;
  logic             iss_req_o;
  logic             iss_rdy_i;
  logic [3:0]       iss_opc_o;
  logic [TAG_W-1:0] iss_tag_o;
  logic [31:0]      iss_src1_o, iss_src2_o;

  int   errors = 0;
  int   checks = 0;
  iss_t sb[$];

  alu_rvs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp_req_i(disp_req_i), .disp_rdy_o(disp_rdy_o),
    .disp_opc_i(disp_opc_i), .disp_tag_i(disp_tag_i),
    .disp_src1_vld_i(disp_src1_vld_i), .disp_src2_vld_i(disp_src2_vld_i),
    .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
    .disp_src1_data_i(disp_src1_data_i), .disp_src2_data_i(disp_src2_data_i),
    .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .iss_req_o(iss_req_o), .iss_rdy_i(iss_rdy_i),
    .iss_opc_o(iss_opc_o), .iss_tag_o(iss_tag_o),
    .iss_src1_o(iss_src1_o), .iss_src2_o(iss_src2_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every accepted issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && !flush_i && iss_req_o && iss_rdy_i) begin
      iss_t exp_v;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got tag=%0h s1=%0h s2=%0h, required no issue",
                 iss_tag_o, iss_src1_o, iss_src2_o);
      end else begin
        exp_v = sb.pop_front();
        if ({iss_opc_o, iss_tag_o, iss_src1_o, iss_src2_o} !== exp_v) begin
          errors++;
          $display("FAIL issue_payload: got opc=%0h tag=%0h s1=%0h s2=%0h, required opc=%0h tag=%0h s1=%0h s2=%0h",
                   iss_opc_o, iss_tag_o, iss_src1_o, iss_src2_o,
                   exp_v.opc, exp_v.tag, exp_v.s1, exp_v.s2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req_i = 1'b0;
    cdb_vld_i  = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] opc, input logic [TAG_W-1:0] tag,
                          input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1,
                          input logic v2, input logic [TAG_W-1:0] t2, input logic [31:0] d2);
    disp_req_i       = 1'b1;
    disp_opc_i       = opc;
    disp_tag_i       = tag;
    disp_src1_vld_i  = v1;
    disp_src1_tag_i  = t1;
    disp_src1_data_i = d1;
    disp_src2_vld_i  = v2;
    disp_src2_tag_i  = t2;
    disp_src2_data_i = d2;
  endtask

  task automatic push_exp(input logic [3:0] opc, input logic [TAG_W-1:0] tag,
                          input logic [31:0] s1, input logic [31:0] s2);
    iss_t e;
    e.opc = opc; e.tag = tag; e.s1 = s1; e.s2 = s2;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    iss_rdy_i = 1'b0;
    set_disp(4'h0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    disp_req_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_disp_rdy: got %b, required 1", disp_rdy_o); end
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL reset_iss_req: got %b, required 0", iss_req_o); end
  endtask

  task automatic test_basic();
    iss_rdy_i = 1'b1;
    step();
    set_disp(4'h1, 4'h9, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
    push_exp(4'h1, 4'h9, 32'd5, 32'd7);
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL basic_no_same_cycle_issue: got %b, required 0", iss_req_o); end
    step();
    idle();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b1) begin errors++; $display("FAIL basic_issue_next_cycle: got %b, required 1", iss_req_o); end
    step();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL basic_empty_after: got iss_req=%b, required 0", iss_req_o); end
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL basic_rdy_after: got disp_rdy=%b, required 1", disp_rdy_o); end
  endtask

  task automatic test_wakeup();
    iss_rdy_i = 1'b1;
    step();
    set_disp(4'h2, 4'h5, 1'b0, 4'h3, 32'hDEAD, 1'b1, '0, 32'd2);
    push_exp(4'h2, 4'h5, 32'h1234, 32'd2);
    step();
    idle();
    cdb_vld_i = 1'b1; cdb_tag_i = 4'h3; cdb_data_i = 32'h1234;
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL wakeup_not_ready_yet: got %b, required 0", iss_req_o); end
    step();
    idle();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b1) begin errors++; $display("FAIL wakeup_issue: got %b, required 1", iss_req_o); end
    step();
  endtask

  task automatic test_bypass();
    iss_rdy_i = 1'b1;
    step();
    set_disp(4'h3, 4'h7, 1'b1, '0, 32'd11, 1'b0, 4'h6, 32'hBEEF);
    cdb_vld_i = 1'b1; cdb_tag_i = 4'h6; cdb_data_i = 32'hAA;
    push_exp(4'h3, 4'h7, 32'd11, 32'hAA);
    step();
    idle();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b1) begin errors++; $display("FAIL bypass_issue: got %b, required 1", iss_req_o); end
    step();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL bypass_empty_after: got %b, required 0", iss_req_o); end
  endtask

  task automatic test_full();
    iss_rdy_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      set_disp(4'(k), 4'(k + 1), 1'b1, '0, 32'(100 + k), 1'b1, '0, 32'(200 + k));
      push_exp(4'(k), 4'(k + 1), 32'(100 + k), 32'(200 + k));
      @(negedge clk);
      checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL full_rdy_before_%0d: got %b, required 1", k, disp_rdy_o); end
    end
    step();
    idle();
    @(negedge clk);
    checks++; if (disp_rdy_o !== 1'b0) begin errors++; $display("FAIL full_rdy_when_full: got %b, required 0", disp_rdy_o); end
    checks++; if (iss_req_o !== 1'b1) begin errors++; $display("FAIL full_iss_req_held: got %b, required 1", iss_req_o); end
    step();
    iss_rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (disp_rdy_o !== 1'b0) begin errors++; $display("FAIL full_rdy_issue_cycle: got %b, required 0", disp_rdy_o); end
    step();
    @(negedge clk);
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL full_rdy_after_first_issue: got %b, required 1", disp_rdy_o); end
    repeat (3) step();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL full_drained: got %b, required 0", iss_req_o); end
  endtask

  task automatic test_back_to_back();
    // A waits in entry 0, B ready in entry 1; issue B, wake A and dispatch C together.
    iss_rdy_i = 1'b0;
    step();
    set_disp(4'hA, 4'hA, 1'b0, 4'h5, 32'h0, 1'b1, '0, 32'h20);
    step();
    set_disp(4'hB, 4'hB, 1'b1, '0, 32'h31, 1'b1, '0, 32'h32);
    push_exp(4'hB, 4'hB, 32'h31, 32'h32);
    push_exp(4'hA, 4'hA, 32'h55, 32'h20);
    push_exp(4'hC, 4'hC, 32'h41, 32'h42);
    step();
    iss_rdy_i = 1'b1;
    set_disp(4'hC, 4'hC, 1'b1, '0, 32'h41, 1'b1, '0, 32'h42);
    cdb_vld_i = 1'b1; cdb_tag_i = 4'h5; cdb_data_i = 32'h55;
    @(negedge clk);
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL b2b_disp_rdy: got %b, required 1", disp_rdy_o); end
    step();
    idle();
    repeat (2) step();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b, required 0", iss_req_o); end
  endtask

  task automatic test_flush();
    iss_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      set_disp(4'h4, 4'(k + 8), 1'b0, 4'hF, 32'h0, 1'b1, '0, 32'h9);
    end
    step();
    set_disp(4'h5, 4'hE, 1'b1, '0, 32'h1, 1'b1, '0, 32'h2);
    flush_i = 1'b1;
    @(negedge clk);
    checks++; if (disp_rdy_o !== 1'b0) begin errors++; $display("FAIL flush_blocks_disp: got %b, required 0", disp_rdy_o); end
    step();
    idle();
    iss_rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL flush_iss_req: got %b, required 0", iss_req_o); end
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL flush_disp_rdy: got %b, required 1", disp_rdy_o); end
    step();
    cdb_vld_i = 1'b1; cdb_tag_i = 4'hF; cdb_data_i = 32'h77;
    step();
    idle();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL flush_no_stale_wakeup: got %b, required 0", iss_req_o); end
  endtask

  task automatic test_reset_mid();
    iss_rdy_i = 1'b0;
    step();
    set_disp(4'h6, 4'h1, 1'b1, '0, 32'h61, 1'b1, '0, 32'h62);
    step();
    set_disp(4'h7, 4'h2, 1'b1, '0, 32'h71, 1'b1, '0, 32'h72);
    step();
    idle();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready_before: got %b, required 1", iss_req_o); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_iss_req: got %b, required 0", iss_req_o); end
    checks++; if (disp_rdy_o !== 1'b1) begin errors++; $display("FAIL rstmid_disp_rdy: got %b, required 1", disp_rdy_o); end
    iss_rdy_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++; if (iss_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_stale_issue: got %b, required 0", iss_req_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d outstanding issues, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rvs.md
ALU_RVS -- requirements
Module: alu_rvs

Interface
REQ-001 Parameter DEPTH, 4, number of reservation-station entries, 2..16.
REQ-002 Parameter TAG_W, 4, width of ROB/physical tags.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 flush  in  1  pipeline flush; discards all entries.
REQ-006 disp_req  in  1  dispatch valid.
REQ-007 disp_rdy  out  1  station can accept a dispatch this cycle.
REQ-008 disp_opc  in  4  ALU opcode (alu_op encoding).
REQ-009 disp_tag  in  TAG_W  destination tag.
REQ-010 disp_src1_vld / disp_src2_vld  in  1 each  operand value present.
REQ-011 disp_src1_tag / disp_src2_tag  in  TAG_W each  producer tag when operand not present.
REQ-012 disp_src1_data / disp_src2_data  in  32 each  operand value when present.
REQ-013 cdb_vld  in  1  CDB broadcast valid.
REQ-014 cdb_tag  in  TAG_W  CDB broadcast tag.
REQ-015 cdb_data  in  32  CDB broadcast value.
REQ-016 iss_req  out  1  issue valid to ALU.
REQ-017 iss_rdy  in  1  ALU accepts issue.
REQ-018 iss_opc  out  4; iss_tag  out  TAG_W; iss_src1 / iss_src2  out  32 each  issued operation.

Function
REQ-019 Each entry SHALL hold: busy, opc, tag, and per operand vld, tag, 32-bit data.
REQ-020 disp_rdy SHALL be 1 iff fewer than DEPTH entries busy at start of cycle and flush=0; entries freed by issue in the same cycle are not reusable until next cycle.
REQ-021 On disp_req && disp_rdy, the lowest-index non-busy entry SHALL be written and marked busy at the clock edge.
REQ-022 Dispatch bypass: if disp_srcN_vld=0 and cdb_vld=1 and cdb_tag==disp_srcN_tag in the same cycle, the entry SHALL store cdb_data with vld=1.
REQ-023 Wakeup: every busy entry with srcN vld=0 and srcN tag==cdb_tag while cdb_vld=1 SHALL capture cdb_data and set vld=1 at the clock edge; both operands may wake from one broadcast.
REQ-024 An entry is ready when busy and both operand vld=1 (registered state); an entry woken in cycle N SHALL be eligible in cycle N+1, not N.
REQ-025 iss_req SHALL be 1 iff any entry is ready; select the lowest-index ready entry; iss_opc/iss_tag/iss_src1/iss_src2 SHALL be combinational from that entry, don't-care when iss_req=0.
REQ-026 On iss_req && iss_rdy, the selected entry SHALL be cleared (busy=0) at the clock edge; exactly one issue per cycle.
REQ-027 If iss_rdy=0, selection MAY change between cycles as higher-priority entries become ready; no entry SHALL be lost or duplicated.
REQ-028 Simultaneous dispatch, wakeup, and issue in one cycle SHALL all take effect; an issued entry ignores wakeup.
REQ-029 flush=1 SHALL clear all busy bits at the clock edge, block dispatch that cycle (disp_rdy=0), and take priority over dispatch, wakeup and issue state updates; iss_req remains combinational from pre-flush state.
REQ-030 Full condition: all DEPTH busy -> disp_rdy=0; empty -> iss_req=0.
REQ-031 Latency: operand-ready dispatch in cycle N -> iss_req=1 in cycle N+1 at earliest.

Reset
REQ-032 While rst=1, all busy and operand vld bits SHALL clear at the clock edge; rst takes priority over flush, dispatch and wakeup.
REQ-033 First cycle after reset: disp_rdy=1, iss_req=0; stored data/tag contents are don't-care.
REQ-034 Reset asserted mid-operation SHALL discard all entries with no issue in following cycles.

Verification
REQ-035 Dispatch add, src1=5, src2=7 both vld, iss_rdy=1 -> iss_req=1 next cycle with iss_src1=5, iss_src2=7, iss_tag=disp_tag; station empty after handshake.
REQ-036 Dispatch with src1 waiting on tag 3; cycle later cdb_vld=1, cdb_tag=3, cdb_data=0x1234 -> iss_req=1 following cycle with iss_src1=0x1234.
REQ-037 Dispatch with src2 waiting on tag 6 while cdb broadcasts tag 6 data 0xAA same cycle -> issue next cycle with iss_src2=0xAA.
REQ-038 iss_rdy=0, dispatch DEPTH=4 ready ops -> disp_rdy=0 after fourth; raise iss_rdy -> issues in index order 0,1,2,3, disp_rdy=1 the cycle after first issue.
REQ-039 Three busy entries, flush=1 with concurrent disp_req -> next cycle iss_req=0, disp_rdy=1, no entry from the flushed-cycle dispatch.
REQ-040 rst asserted with two ready entries and iss_rdy=0 -> after reset iss_req=0, disp_rdy=1, no stale issue.
